// File: rtl/aes_stream_pkg.sv
// rtl/aes_stream_pkg.sv - shared widths, block type codes and word selection for the AES output stream
package aes_stream_pkg;

  localparam int BLOCK_W = 128;
  localparam int WORD_W  = 32;
  localparam int ENTRY_W = BLOCK_W + 1;

  localparam logic TYPE_OUT_ENC = 1'b0;
  localparam logic TYPE_OUT_DEC = 1'b1;

  // Word 0 is the most significant 32 bits of the block.
  function automatic logic [WORD_W-1:0] block_word(input logic [BLOCK_W-1:0] blk,
                                                   input logic [1:0]         idx);
    logic [WORD_W-1:0] w;
    case (idx)
      2'd0:    w = blk[127:96];
      2'd1:    w = blk[95:64];
      2'd2:    w = blk[63:32];
      default: w = blk[31:0];
    endcase
    return w;
  endfunction

endpackage

// File: rtl/stream_fifo.sv
// rtl/stream_fifo.sv - block FIFO with wrapping pointers and occupancy; storage is not reset
module stream_fifo
  import aes_stream_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = ENTRY_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [W-1:0]             wr_data,
  input  logic                     rd_en,
  output logic [W-1:0]             rd_data,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0]   LVL_ONE = (AW + 1)'(1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_en) rd_ptr <= rd_ptr + PTR_ONE;
      if (wr_en && !rd_en)      level <= level + LVL_ONE;
      else if (!wr_en && rd_en) level <= level - LVL_ONE;
    end
  end

  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/stream_out_buffer.sv
// rtl/stream_out_buffer.sv - buffers 128-bit cipher blocks and emits them as 32-bit words; STREAM_OUT_CNT_EN adds per-type block counters
module stream_out_buffer
  import aes_stream_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     vin,
  input  logic                     tin,
  input  logic [BLOCK_W-1:0]       din,
  output logic                     out_vld,
  input  logic                     out_rdy,
  output logic [WORD_W-1:0]        out_data,
  output logic                     out_type,
  output logic                     out_last,
  output logic [$clog2(DEPTH):0]   level,
`ifdef STREAM_OUT_CNT_EN
  output logic [15:0]              enc_cnt,
  output logic [15:0]              dec_cnt,
`endif
  output logic                     full,
  output logic                     ovf,
  input  logic                     ovf_clr
);

  localparam int LW = $clog2(DEPTH) + 1;
  localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

  logic [ENTRY_W-1:0] head;
  logic [1:0]         widx;
  logic               xfer;
  logic               pop;
  logic               wr_en;
  logic               drop;

  assign full    = (level == LVL_FULL);
  assign out_vld = (level != '0);
  assign xfer    = out_vld && out_rdy;
  assign pop     = xfer && (widx == 2'd3);
  // A full FIFO still accepts a block when the head entry leaves in the same cycle.
  assign wr_en   = vin && (!full || pop);
  assign drop    = vin && !wr_en;

  stream_fifo #(.DEPTH(DEPTH), .W(ENTRY_W)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_data ({tin, din}),
    .rd_en   (pop),
    .rd_data (head),
    .level   (level)
  );

  // Outputs are gated by out_vld so reset forces them low without waiting for an edge.
  assign out_data = out_vld ? block_word(head[BLOCK_W-1:0], widx) : '0;
  assign out_type = out_vld && head[BLOCK_W];
  assign out_last = out_vld && (widx == 2'd3);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      widx <= 2'd0;
      ovf  <= 1'b0;
    end else begin
      if (xfer)         widx <= widx + 2'd1;
      if (ovf_clr)      ovf  <= 1'b0;
      else if (drop)    ovf  <= 1'b1;
    end
  end

`ifdef STREAM_OUT_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      enc_cnt <= 16'd0;
      dec_cnt <= 16'd0;
    end else if (pop) begin
      if (head[BLOCK_W] == TYPE_OUT_DEC) dec_cnt <= dec_cnt + 16'd1;
      else                               enc_cnt <= enc_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: doc/stream_out_buffer.md
STREAM_OUT_BUFFER -- requirements
Module: stream_out_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, giving the number of 128-bit block entries (power of 2, 2..16).
REQ-002 SHALL have port clk, input, 1 bit: the single clock.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 SHALL have port vin, input, 1 bit: block valid from the cipher core output stream (no backpressure).
REQ-005 SHALL have port tin, input, 1 bit: block type, 0 = ENC, 1 = DEC.
REQ-006 SHALL have port din, input, 128 bits: result block.
REQ-007 SHALL have port out_vld, output, 1 bit: word valid.
REQ-008 SHALL have port out_rdy, input, 1 bit: downstream ready.
REQ-009 SHALL have port out_data, output, 32 bits: current word.
REQ-010 SHALL have port out_type, output, 1 bit: type of the block being emitted.
REQ-011 SHALL have port out_last, output, 1 bit: asserted on the 4th word of a block.
REQ-012 SHALL have port level, output, $clog2(DEPTH)+1 bits: occupied entries.
REQ-013 SHALL have port full, output, 1 bit: level == DEPTH.
REQ-014 SHALL have port ovf, output, 1 bit: sticky overflow flag.
REQ-015 SHALL have port ovf_clr, input, 1 bit: clears ovf.

Function
REQ-016 SHALL write {tin, din} into the FIFO on every cycle with vin=1 that is not full, or that is full while the last word of the head block pops in the same cycle.
REQ-017 SHALL drop the block on any other vin=1 while full, leaving FIFO contents unchanged, and set ovf on the next edge.
REQ-018 SHALL emit the head block as 4 words, most significant first: din[127:96], [95:64], [63:32], [31:0].
REQ-019 SHALL advance the word index only on out_vld & out_rdy, and pop the entry after the transfer of word 3 (out_last=1).
REQ-020 SHALL keep out_data, out_type and out_last stable while out_vld=1 and out_rdy=0.
REQ-021 SHALL have latency such that a block written at edge N presents word 0 with out_vld=1 in cycle N+1 when the FIFO was empty.
REQ-022 SHALL hold out_vld=0 whenever level==0; with a continuous out_rdy=1, SHALL sustain one word per cycle back-to-back across blocks.
REQ-023 SHALL wrap read/write pointers modulo DEPTH; level SHALL be +1 on write only, -1 on pop only, and unchanged on both.
REQ-024 SHALL give ovf_clr priority over a same-cycle overflow event (ovf=0 after the edge).

Reset
REQ-025 SHALL, on rst asserted at any time including mid-block, asynchronously force out_vld=0, out_data=0, out_type=0, out_last=0, level=0, full=0, ovf=0, pointers=0 and word index=0; partial blocks are discarded.
REQ-026 SHALL NOT clear FIFO storage RAM on reset.

Configuration
REQ-027 With STREAM_OUT_CNT_EN defined, SHALL add outputs enc_cnt and dec_cnt, each 16 bits, counting fully emitted blocks per type, wrapping at 0xFFFF->0 and reset to 0; without the macro, these ports and counters SHALL be absent.

Structure
REQ-028 SHALL place TYPE_OUT_ENC/TYPE_OUT_DEC, BLOCK_W=128 and WORD_W=32 in shared package aes_stream_pkg.
REQ-029 SHALL implement storage and pointers in sub-module stream_fifo (width 129, depth DEPTH); serializer and flags SHALL be in the top.

Verification
REQ-030 Single block: vin=1, tin=0, din=0x00112233_44556677_8899AABB_CCDDEEFF, out_rdy=1 -> words 0x00112233, 0x44556677, 0x8899AABB, 0xCCDDEEFF in cycles N+1..N+4, out_last on the 4th, out_type=0.
REQ-031 Backpressure: out_rdy=0 for 5 cycles after word 1 -> out_data held at 0x44556677 and out_vld=1, with no word skipped or duplicated.
REQ-032 Overflow: with out_rdy=0, write 5 blocks into DEPTH=4 -> level=4, full=1, ovf=1, 5th block absent from output; then ovf_clr=1 -> ovf=0.
REQ-033 Full plus pop: full, out_rdy=1 on word 3, vin=1 same cycle -> block accepted, level stays 4, ovf stays 0.
REQ-034 Reset mid-block: rst asserted after word 2 -> out_vld=0 and level=0 immediately; a new block after release starts at word 0.
REQ-035 STREAM_OUT_CNT_EN: 3 ENC and 2 DEC blocks drained -> enc_cnt=3, dec_cnt=2.
